bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Downstream consumer of the calculator's binary-to-BCD converter. Captures an 8-nibble signed-BCD word (nibble 7 = sign, nibbles 6..0 = magnitude digits) and drives a multiplexed 8-digit common-anode seven-segment display. Optionally blanks leading zeros and floats the minus sign. New values are applied only at frame boundaries so a displayed number never tears.

## Interface
- `SCAN_DIV`, default 50000: clocks per digit slot; must be ≥ 2; prescaler width is $clog2(SCAN_DIV).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock domain; reset is asynchronous and active-low.
- `bcd_in`  in  32  signed BCD word.
  - Nibble codes 0–9 are digits.
  - 4'hE is minus.
  - 4'hF is blank.
  - 4'hA–4'hD display as blank.
- `bcd_valid`  in  1  single-cycle load strobe; always accepted, no backpressure.
- `pending`  out  1  high while a loaded word awaits commit.
- `an_n`  out  8  active-low digit enables; bit k = digit k, where digit 0 is rightmost and maps to `bcd_in[3:0]`.
- `seg_n`  out  8  active-low segments `{dp,g,f,e,d,c,b,a}`; dp is always 1.

## Operation
- Registers:
  - `shadow` (32): load buffer.
  - `disp` (32): committed, post-blanking nibbles.
  - `pending`.
  - Prescaler `cnt`.
  - Digit index `idx` (3 bits).
  - Output registers for `an_n` and `seg_n`.
- Load: on `bcd_valid`, `shadow <= bcd_in` and `pending <= 1`. Repeated loads before commit: last one wins.
- Prescaler: `cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `cnt == SCAN_DIV-1`.
- Scan: on `tick`, `idx` increments modulo 8. `an_n` and `seg_n` are registered on the same edge and reflect the new `idx`.
  - `an_n` = one-cold at `idx`.
  - `seg_n` = decode(`disp` nibble at `idx`).
- Commit: on the `tick` where `idx` wraps 7→0, if `pending`:
  - `disp <= fmt(shadow)` and `pending <= 0`.
  - The `seg_n` produced on that same edge for digit 0 already uses the new value.
- Simultaneous `bcd_valid` and commit: the commit uses `shadow` as it was before the edge. The new word overwrites `shadow` and `pending` stays 1.
- Decode:
  - 0 → C0, 1 → F9, 2 → A4, 3 → B0, 4 → 99, 5 → 92, 6 → 82, 7 → F8, 8 → 80, 9 → 90.
  - E (minus) → BF.
  - All other codes → FF.
- `fmt` is combinational over 32 bits and behaves per Configuration.

## Timing
- Reset values:
  - `an_n = 8'hFF`, `seg_n = 8'hFF`, `pending = 0`.
  - `cnt = 0`, `idx = 7`, so the first tick selects digit 0.
  - `shadow` and `disp` = 32'hFFFF_FFFF (all blank).
- Reset is asynchronous. Asserting it mid-frame forces all of the above immediately, and any pending load is lost.
- First digit enable occurs SCAN_DIV clocks after reset release. After that, each digit is lit for SCAN_DIV clocks and a frame lasts 8·SCAN_DIV clocks.
- Load-to-visible latency: from the `bcd_valid` edge to the next 7→0 wrap, between 1 and 8·SCAN_DIV clocks.
- `pending` rises on the edge after `bcd_valid` and falls on the commit edge.

## Configuration
- Macro: `BCD_DISPLAY_LZB_EN`.
- Defined (leading-zero blanking):
  - Scanning digits 6 down to 1, a 0 nibble becomes F while all higher magnitude digits are 0. Digit 0 is never blanked.
  - If nibble 7 is E, the minus moves to the digit immediately left of the most significant non-blank digit, and nibble 7 becomes F. If digit 6 is significant, the minus stays in digit 7.
- Undefined: `fmt` is the identity, and nibbles are displayed verbatim.

## Structure
- Package `calc_disp_pkg`:
  - `NIB_MINUS = 4'hE`, `NIB_BLANK = 4'hF`.
  - `SEG_BLANK = 8'hFF`, `SEG_MINUS = 8'hBF`.
  - Typedef `bcd_word_t` (logic [31:0]).
- Sub-module `seg7_decode`: combinational 4-bit nibble → 8-bit `seg_n`, implementing the decode table.
- `fmt` is a function in the main module.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset, then run one frame with no load → `an_n` walks FE, FD, … 7F, one step every 4 clocks; `seg_n` = FF throughout; `pending` = 0.
- Load 32'hF000_0123 with LZB_EN → after the next wrap, digits 0/1/2 show 3/2/1 (B0/A4/F9), digits 3–7 are FF, and `pending` pulses high until the commit.
- Load 32'hE000_0045:
  - With LZB_EN → digit 2 = BF, digit 7 = FF.
  - Without LZB_EN → digit 7 = BF and digits 2–6 = C0.
- Load 32'hF000_0000 with LZB_EN → only digit 0 is lit, showing C0.
- Tearing and races:
  - Load at idx 3 → digits 4–7 still show the old word; the new word appears from digit 0.
  - Two loads within one frame → the second is displayed.
  - A load on the commit cycle → the old `shadow` is committed, `pending` stays 1, and the new word commits at the next wrap.
- Assert `rst_n` low mid-frame (asynchronously, between edges) → `an_n` and `seg_n` go FF with no clock edge, and after release the display is blank until a new load commits.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared nibble codes, segment patterns and the BCD word type for the
// calculator display path.
package calc_disp_pkg;

    localparam logic [3:0] NIB_MINUS = 4'hE;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef logic [31:0] bcd_word_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp stays dark.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        unique case (nib)
            4'h0:      seg_n = 8'hC0;
            4'h1:      seg_n = 8'hF9;
            4'h2:      seg_n = 8'hA4;
            4'h3:      seg_n = 8'hB0;
            4'h4:      seg_n = 8'h99;
            4'h5:      seg_n = 8'h92;
            4'h6:      seg_n = 8'h82;
            4'h7:      seg_n = 8'hF8;
            4'h8:      seg_n = 8'h80;
            4'h9:      seg_n = 8'h90;
            NIB_MINUS: seg_n = SEG_MINUS;
            default:   seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 8-digit seven-segment scanner for signed BCD words; loads are
// committed only at frame wrap. Define BCD_DISPLAY_LZB_EN for leading-zero
// blanking with a floating minus sign.
module bcd_display_scan
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic      clk,
    input  logic      rst_n,
    input  bcd_word_t bcd_in,
    input  logic      bcd_valid,
    output logic      pending,
    output logic [7:0] an_n,
    output logic [7:0] seg_n
);

    localparam int               CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    bcd_word_t        shadow;
    bcd_word_t        disp;
    bcd_word_t        disp_nxt;
    logic             tick;
    logic             commit;
    logic [3:0]       nib;
    logic [7:0]       seg_d;

    function automatic bcd_word_t fmt(input bcd_word_t w);
`ifdef BCD_DISPLAY_LZB_EN
        bcd_word_t r;
        logic      lead;
        int        pos;
        r    = w;
        lead = 1'b1;
        pos  = -1;
        for (int k = 6; k >= 1; k--) begin
            if (lead && w[k*4 +: 4] == 4'h0)
                r[k*4 +: 4] = NIB_BLANK;
            else
                lead = 1'b0;
        end
        for (int k = 0; k <= 6; k++) begin
            if (r[k*4 +: 4] != NIB_BLANK)
                pos = k;
        end
        // Minus floats to just left of the most significant lit digit;
        // with nothing lit it lands in digit 0.
        if (w[31:28] == NIB_MINUS) begin
            r[31:28]          = NIB_BLANK;
            r[(pos+1)*4 +: 4] = NIB_MINUS;
        end
        return r;
`else
        return w;
`endif
    endfunction

    assign tick     = (cnt == CNT_MAX);
    assign commit   = tick && (idx == 3'd7) && pending;
    assign idx_nxt  = idx + 3'd1;
    // The digit-0 pattern on the commit edge must already see the new word.
    assign disp_nxt = commit ? fmt(shadow) : disp;
    assign nib      = disp_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_decode u_dec (
        .nib   (nib),
        .seg_n (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= 3'd7;
            an_n    <= 8'hFF;
            seg_n   <= SEG_BLANK;
            shadow  <= '1;
            disp    <= '1;
            pending <= 1'b0;
        end else begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            disp <= disp_nxt;
            if (tick) begin
                idx   <= idx_nxt;
                an_n  <= ~(8'b1 << idx_nxt);
                seg_n <= seg_d;
            end
            // A load on the commit edge keeps pending set for the next frame.
            if (bcd_valid) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized bench for bcd_display_scan against a frame-level behavioural
// model; honours BCD_DISPLAY_LZB_EN the same way the design build does.
module tb_bcd_display_scan;
    import calc_disp_pkg::*;

    localparam int SD = 4;
    localparam logic [7:0] SEGS [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                         8'h82, 8'hF8, 8'h80, 8'h90, 8'hFF, 8'hFF,
                                         8'hFF, 8'hFF, 8'hBF, 8'hFF};

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    bcd_word_t bcd_in = '0;
    logic      bcd_valid = 1'b0;
    logic      pending;
    logic [7:0] an_n;
    logic [7:0] seg_n;

    int checks = 0;
    int errors = 0;

    int        e;
    bcd_word_t m_shadow, m_disp;
    logic      m_pend;
    logic [7:0] exp_an, exp_seg;

    bcd_display_scan #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .pending   (pending),
        .an_n      (an_n),
        .seg_n     (seg_n)
    );

    always #5 clk = ~clk;

    function automatic bcd_word_t model_fmt(input bcd_word_t w);
`ifdef BCD_DISPLAY_LZB_EN
        logic [3:0] d [8];
        int top, msd;
        bcd_word_t r;
        for (int i = 0; i < 8; i++) d[i] = w[4*i +: 4];
        top = 0;
        for (int i = 1; i <= 6; i++) if (d[i] != 4'h0) top = i;
        for (int i = top + 1; i <= 6; i++) d[i] = 4'hF;
        msd = -1;
        for (int i = 0; i <= 6; i++) if (d[i] != 4'hF) msd = i;
        if (d[7] == 4'hE) begin
            d[7] = 4'hF;
            d[msd + 1] = 4'hE;
        end
        for (int i = 0; i < 8; i++) r[4*i +: 4] = d[i];
        return r;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_shadow = '1;
        m_disp = '1;
        m_pend = 1'b0;
        exp_an = 8'hFF;
        exp_seg = 8'hFF;
    endtask

    task automatic model_edge(input logic v, input bcd_word_t d);
        int   slot;
        logic commit;
        if (!rst_n) return;
        e++;
        commit = 1'b0;
        if (e % SD == 0) begin
            slot = (e / SD - 1) % 8;
            if (slot == 0 && m_pend) begin
                m_disp = model_fmt(m_shadow);
                commit = 1'b1;
            end
            exp_an  = ~(8'h01 << slot);
            exp_seg = SEGS[m_disp[slot*4 +: 4]];
        end
        if (v) begin
            m_shadow = d;
            m_pend = 1'b1;
        end else if (commit) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic step(input logic v, input bcd_word_t d);
        bcd_valid = v;
        bcd_in = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        chk("an_n", {24'h0, an_n}, {24'h0, exp_an});
        chk("seg_n", {24'h0, seg_n}, {24'h0, exp_seg});
        chk("pending", {31'h0, pending}, {31'h0, m_pend});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom());
    endtask

    task automatic seek_digit(input string name, input logic [7:0] an, input logic [7:0] seg);
        int n = 0;
        while (an_n !== an && n < 40) begin
            step(1'b0, '0);
            n++;
        end
        if (an_n !== an) chk({name, "_timeout"}, {24'h0, an_n}, {24'h0, an});
        else             chk(name, {24'h0, seg_n}, {24'h0, seg});
    endtask

    function automatic logic next_is_wrap();
        return ((e + 1) % SD == 0) && (((e + 1) / SD - 1) % 8 == 0);
    endfunction

    function automatic bcd_word_t rand_word();
        bcd_word_t w;
        int nz;
        w[31:28] = $urandom_range(0, 1) ? 4'hE : 4'hF;
        nz = $urandom_range(0, 7);
        for (int k = 0; k < 7; k++)
            w[4*k +: 4] = (k >= 7 - nz) ? 4'h0 : 4'($urandom_range(0, 9));
        return w;
    endfunction

    initial begin
        int n;
        model_reset();
        #12;
        chk("reset_an", {24'h0, an_n}, 32'hFF);
        chk("reset_seg", {24'h0, seg_n}, 32'hFF);
        chk("reset_pending", {31'h0, pending}, 32'h0);
        chk("fmt_0123", model_fmt(32'hF000_0123),
`ifdef BCD_DISPLAY_LZB_EN
            32'hFFFF_F123);
`else
            32'hF000_0123);
`endif
        chk("fmt_0045", model_fmt(32'hE000_0045),
`ifdef BCD_DISPLAY_LZB_EN
            32'hFFFF_FE45);
`else
            32'hE000_0045);
`endif
        #10 rst_n = 1'b1;

        idle(3);
        chk("pre_tick_an", {24'h0, an_n}, 32'hFF);
        idle(1);
        chk("first_tick_an", {24'h0, an_n}, 32'hFE);
        idle(8 * SD);

        step(1'b1, 32'hF000_0123);
        idle(2 * 8 * SD);
        seek_digit("d1_0123", 8'hFD, 8'hA4);
`ifdef BCD_DISPLAY_LZB_EN
        seek_digit("d3_0123", 8'hF7, 8'hFF);
`else
        seek_digit("d3_0123", 8'hF7, 8'hC0);
`endif

        step(1'b1, 32'hE000_0045);
        idle(2 * 8 * SD);
`ifdef BCD_DISPLAY_LZB_EN
        seek_digit("d2_minus", 8'hFB, 8'hBF);
        seek_digit("d7_minus", 8'h7F, 8'hFF);
`else
        seek_digit("d2_minus", 8'hFB, 8'hC0);
        seek_digit("d7_minus", 8'h7F, 8'hBF);
`endif

        step(1'b1, 32'hF000_0000);
        idle(2 * 8 * SD);
        seek_digit("d0_zero", 8'hFE, 8'hC0);

        // Load while digit 3 is lit: upper digits keep the old word until wrap.
        seek_digit("d3_before_load", 8'hF7, SEGS[m_disp[15:12]]);
        step(1'b1, 32'hE012_3456);
        idle(SD);
        step(1'b1, 32'hF987_6543);
        idle(2 * 8 * SD);

        // Load coinciding with the commit edge.
        step(1'b1, 32'hF000_0777);
        n = 0;
        while (!next_is_wrap() && n < 40) begin
            step(1'b0, '0);
            n++;
        end
        step(1'b1, 32'hF000_0888);
        chk("race_pending", {31'h0, pending}, 32'h1);
        chk("race_old_commit", {24'h0, seg_n}, 32'hF8);
        idle(8 * SD);
        chk("race_new_commit", {24'h0, seg_n}, 32'h80);
        idle(8 * SD);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) step(1'b1, rand_word());
            else                            step(1'b0, $urandom());
        end

        // Asynchronous reset between clock edges, with a load still pending.
        step(1'b1, 32'hF000_0555);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {24'h0, an_n}, 32'hFF);
        chk("async_seg", {24'h0, seg_n}, 32'hFF);
        chk("async_pending", {31'h0, pending}, 32'h0);
        model_reset();
        idle(3);
        #3 rst_n = 1'b1;
        idle(2 * 8 * SD);
        step(1'b1, 32'hE000_0009);
        idle(2 * 8 * SD);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) step(1'b1, rand_word());
            else                           step(1'b0, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
